spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master transaction controller for the SPI subsystem. It derives SCLK from the system clock by an integer divisor, the same scheme as the team's clock divider but gated per transaction. It sequences chip-select, shifting and sampling for one DATA_WIDTH-bit full-duplex mode-0 transfer per start request. It sits between a host register/FSM interface (start/busy/done handshake) and the off-chip SPI slave pins.

## Interface
- DATA_WIDTH, 8: bits per transfer, MSB first; legal range 1–32.
- DIVISOR, 4: clock_in cycles per SCLK period; must be even and ≥2. Half-period H = DIVISOR/2.
- clock_in  input  1  system clock; all logic on its rising edge; one clock domain only.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  transfer request, sampled only in IDLE.
- tx_data  input  DATA_WIDTH  word to send; latched on the accepting edge.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- rx_data  output  DATA_WIDTH  last received word; held until the next done.
- cs_n  output  1  slave select, active-low.
- sclk  output  1  SPI clock, CPOL=0.
- mosi  output  1  serial data out, changes on falling SCLK.
- miso  input  1  serial data in, sampled on rising SCLK; synchronous to clock_in at the bench.

## Operation
- States: IDLE, SETUP, XFER_HI, XFER_LO, HOLD.
- Half-period counter, 16 bits, counts 0..H-1. tick = (counter == H-1). The counter clears on every state change and is held at 0 in IDLE.
- IDLE: cs_n=1, sclk=0, busy=0.
  - start=1 latches tx_data into the shift register, clears the bit counter, and goes to SETUP.
- SETUP: cs_n=0, sclk=0, mosi=shift[MSB].
  - On tick: sclk←1, sample miso into the receive register LSB (shift left), go to XFER_HI.
- XFER_HI: sclk=1.
  - On tick: sclk←0 and bit counter +1.
  - If the bit counter reached DATA_WIDTH, go to HOLD.
  - Otherwise shift tx left, mosi←next bit, go to XFER_LO.
- XFER_LO: sclk=0.
  - On tick: sclk←1, sample miso, go to XFER_HI.
- HOLD: cs_n=0, sclk=0.
  - On tick go to IDLE; on that same edge: cs_n←1, busy←0, done←1, rx_data←receive register.
- start is ignored in every state except IDLE; no queuing.
- Back-to-back: start=1 during the done cycle is accepted, since the block is in IDLE.
- tx_data changes after the accepting edge have no effect on the current transfer.
- mosi=0 whenever cs_n=1.

## Timing
- Reset values, applied asynchronously and held while reset_n=0:
  - state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, counters=0.
- Reset mid-transfer aborts immediately. There is no done pulse, and rx_data is 0 after release.
- Let E0 be the edge where start is accepted.
  - busy=1 and cs_n=0 from E0 through E0+(2·DATA_WIDTH+1)·H−1.
  - Defaults (W=8, H=2): 34 cycles busy; done=1 in cycle E34 only.
- First rising SCLK occurs H cycles after E0.
- Exactly DATA_WIDTH rising SCLK edges per transfer, each high for H cycles.
- Low phase is H cycles, except: the first (SETUP) is H and the last (HOLD) is H.
- miso is registered on the clock_in edge on which sclk goes 1.
- mosi updates on the edge on which sclk goes 0.
- rx_data and done update on the same edge. rx_data stays stable from that edge until the next done.
- Minimum gap between transfers: 0 cycles of cs_n=1 beyond the single done cycle (cs_n high for ≥1 cycle).

## Test plan
- Loopback (miso tied to mosi), W=8, DIVISOR=4, tx_data=0xA5, pulse start:
  - busy high exactly 34 cycles; 8 SCLK rises; done one cycle; rx_data=0xA5; cs_n=1 after.
- Slave model shifting out 0x3C on falling SCLK, tx_data=0xFF:
  - mosi high for all 8 bits; rx_data=0x3C; MSB is received first.
- start held high continuously and tx_data changed to 0x00 mid-transfer:
  - first transfer still sends 0xA5; a second transfer starts on the done cycle; cs_n high exactly 1 cycle between transfers.
- reset_n pulsed low after the 3rd SCLK rise:
  - cs_n=1, sclk=0, busy=0 asynchronously; no done pulse; rx_data=0.
  - A subsequent start with 0x5A completes correctly.
- DIVISOR=2, W=8, loopback 0x81:
  - SCLK high/low 1 cycle each; busy 17 cycles; rx_data=0x81.
- start pulsed while busy (cycle 10 of a transfer):
  - ignored; exactly one done pulse; busy length unchanged.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master, one DATA_WIDTH-bit full-duplex transfer per start
//   clock_in/reset_n : system clock, async active-low reset
//   start/tx_data    : request and word to send (latched when accepted in IDLE)
//   busy/done        : transfer in progress / one-cycle completion pulse
//   rx_data          : last received word, updated with done
//   cs_n/sclk/mosi   : slave pins driven by the master
//   miso             : slave data in, sampled when sclk rises
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIVISOR    = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int H = DIVISOR / 2;
  typedef enum logic [2:0] {IDLE, SETUP, XFER_HI, XFER_LO, HOLD} state_t;
  state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [5:0] bits, bits_d;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_d, rx_sh, rx_sh_d, rx_data_d;
  logic cs_n_d, sclk_d, mosi_d, busy_d, done_d, tick;
  assign tick = cnt == 16'(H - 1);
  // All pin outputs are registered: next values are computed here and
  // take effect on the edge where the state transition happens.
  always_comb begin
    state_d   = state;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    bits_d    = bits;
    rx_data_d = rx_data;
    cs_n_d    = cs_n;
    sclk_d    = sclk;
    mosi_d    = mosi;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = SETUP;
        tx_sh_d = tx_data;
        rx_sh_d = '0;
        bits_d  = '0;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        mosi_d  = tx_data[DATA_WIDTH-1];
      end
      SETUP, XFER_LO: if (tick) begin
        state_d = XFER_HI;
        sclk_d  = 1'b1;
        rx_sh_d = (rx_sh << 1) | DATA_WIDTH'(miso);
      end
      XFER_HI: if (tick) begin
        sclk_d = 1'b0;
        bits_d = bits + 6'd1;
        if (bits_d == 6'(DATA_WIDTH)) state_d = HOLD;
        else begin
          state_d = XFER_LO;
          tx_sh_d = tx_sh << 1;
          mosi_d  = tx_sh_d[DATA_WIDTH-1];
        end
      end
      HOLD: if (tick) begin
        state_d   = IDLE;
        cs_n_d    = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        mosi_d    = 1'b0;
        rx_data_d = rx_sh;
      end
      default: state_d = IDLE;
    endcase
    // Half-period counter restarts on every state change and idles at zero.
    cnt_d = (state == IDLE || state_d != state) ? '0 : cnt + 16'd1;
  end
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bits    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bits    <= bits_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      rx_data <= rx_data_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed scoreboard bench for spi_master_ctrl (DIVISOR 4 and 2)
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, lb, miso, busy, done, cs_n, sclk, mosi;
  logic [7:0] tx, rx, slave_word, slv;
  logic start_b, busy_b, done_b, cs_n_b, sclk_b, mosi_b;
  logic [7:0] tx_b, rx_b;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$], mosi_q[$];
  int dones = 0, busy_len = 0, busy_run = 0, rises = 0, hi_run = 0, cs_gap = 0, cs_run = 0;
  logic [7:0] mosi_word = 8'h00;
  logic p_busy = 1'b0, p_sclk = 1'b0, p_cs = 1'b1, s_prev = 1'b0;
  assign miso = lb ? mosi : slv[7];
  spi_master_ctrl #(.DATA_WIDTH(8), .DIVISOR(4)) dut (
    .clock_in(clk), .reset_n(rst_n), .start(start), .tx_data(tx), .busy(busy), .done(done),
    .rx_data(rx), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso));
  spi_master_ctrl #(.DATA_WIDTH(8), .DIVISOR(2)) dut_b (
    .clock_in(clk), .reset_n(rst_n), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
    .rx_data(rx_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Slave model: presents slave_word MSB first, shifting after each falling sclk.
  always @(posedge clk) begin
    if (cs_n) slv <= slave_word;
    else if (s_prev && !sclk) slv <= slv << 1;
    s_prev <= sclk;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      p_busy = 1'b0; p_sclk = 1'b0; p_cs = 1'b1; busy_run = 0; hi_run = 0; cs_run = 0;
    end else begin
      if (busy) busy_run++;
      else begin
        if (p_busy) busy_len = busy_run;
        busy_run = 0;
      end
      if (cs_n) cs_run++;
      else begin
        if (p_cs) begin cs_gap = cs_run; rises = 0; mosi_word = 8'h00; end
        cs_run = 0;
      end
      if (sclk && !p_sclk) begin rises++; mosi_word = {mosi_word[6:0], mosi}; end
      if (sclk) hi_run++;
      else begin
        if (p_sclk) check("sclk_high_len", hi_run, 2);
        hi_run = 0;
      end
      if (done) begin
        dones++;
        check("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("rx_data", rx, exp_q.pop_front());
          check("mosi_bits", mosi_word, mosi_q.pop_front());
        end
      end
      p_busy = busy; p_sclk = sclk; p_cs = cs_n;
    end
  end
  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    check("done_timeout", done, 1);
  endtask
  task automatic run(input logic [7:0] t, input logic [7:0] erx, input logic [7:0] emosi);
    tx = t; start = 1'b1;
    exp_q.push_back(erx); mosi_q.push_back(emosi);
    @(posedge clk); #1 start = 1'b0; tx = ~t;
    wait_done();
    @(negedge clk);
    check("busy_len", busy_len, 34);
    check("sclk_rises", rises, 8);
    check("cs_n_after", cs_n, 1);
    check("mosi_idle", mosi, 0);
  endtask
  initial begin
    int n, d0, bcnt, brises, hi_b, lo_b, max_hi, max_lo;
    rst_n = 1'b0; start = 1'b0; tx = 8'h00; lb = 1'b1; slave_word = 8'h00;
    start_b = 1'b0; tx_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1); check("rst_sclk", sclk, 0); check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_rx", rx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(8'hA5, 8'hA5, 8'hA5);
    check("one_done", dones, 1);
    lb = 1'b0; slave_word = 8'h3C;
    run(8'hFF, 8'h3C, 8'hFF);
    slave_word = 8'hC5;
    run(8'hFF, 8'hC5, 8'hFF);
    lb = 1'b1;
    // start held high; tx changed right after acceptance
    tx = 8'hA5; start = 1'b1;
    exp_q.push_back(8'hA5); mosi_q.push_back(8'hA5);
    exp_q.push_back(8'h00); mosi_q.push_back(8'h00);
    @(posedge clk); #1 tx = 8'h00;
    wait_done();
    @(posedge clk); #1 start = 1'b0;
    check("b2b_busy_now", busy, 1);
    wait_done();
    @(negedge clk);
    check("b2b_cs_gap", cs_gap, 1);
    check("b2b_busy_len", busy_len, 34);
    // start pulsed during a transfer is ignored
    d0 = dones;
    tx = 8'h66; start = 1'b1;
    exp_q.push_back(8'h66); mosi_q.push_back(8'h66);
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1; tx = 8'hFF;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    check("ignored_busy_len", busy_len, 34);
    check("ignored_one_done", dones, d0 + 1);
    check("ignored_idle", busy, 0);
    // reset in the low phase after the third rising sclk
    d0 = dones;
    tx = 8'hC3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while ((rises < 3 || sclk) && n < 200) begin @(negedge clk); n++; end
    check("rise3_timeout", 32'(n < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 1); check("arst_sclk", sclk, 0);
    check("arst_busy", busy, 0); check("arst_mosi", mosi, 0); check("arst_rx", rx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done", dones, d0);
    check("arst_rx_after", rx, 0);
    @(posedge clk); #1;
    run(8'h5A, 8'h5A, 8'h5A);
    // DIVISOR=2 instance, loopback
    tx_b = 8'h81; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0; bcnt = 0; brises = 0; hi_b = 0; lo_b = 0; max_hi = 0; max_lo = 0;
    p_sclk = 1'b0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (done_b) break;
      if (busy_b) bcnt++;
      if (sclk_b) begin
        if (hi_b == 0) brises++;
        hi_b++;
        if (lo_b > max_lo) max_lo = lo_b;
        lo_b = 0;
      end else begin
        if (hi_b > max_hi) max_hi = hi_b;
        hi_b = 0;
        if (busy_b) lo_b++;
      end
    end
    if (lo_b > max_lo) max_lo = lo_b;
    check("div2_done", done_b, 1);
    check("div2_busy_len", bcnt, 17);
    check("div2_rises", brises, 8);
    check("div2_hi_len", max_hi, 1);
    check("div2_lo_len", max_lo, 1);
    check("div2_rx", rx_b, 8'h81);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
